// File: rtl/div_eight_pkg.sv
// Shared ALU definitions for the sequential divider: data width, FSM states
// and the fixed quotient reported for a divide by zero.
package div_eight_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [DATA_W-1:0] DIV0_QUOT = 8'hFF;

endpackage

// File: rtl/div_eight_sub.sv
// 8-bit ripple subtractor: half-subtractor on the LSB, full-subtractor chain
// above it. With en_i low the minuend passes through with no borrow.
module div_eight_sub
  import div_eight_pkg::*;
(
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] diff_o,
  output logic              borrow_o
);

  logic [DATA_W-1:0] d;
  logic [DATA_W:0]   bw;

  always_comb begin
    d     = '0;
    bw    = '0;
    d[0]  = a_i[0] ^ b_i[0];
    bw[1] = ~a_i[0] & b_i[0];
    for (int unsigned i = 1; i < DATA_W; i++) begin
      d[i]    = a_i[i] ^ b_i[i] ^ bw[i];
      bw[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bw[i]);
    end
  end

  assign diff_o   = en_i ? d : a_i;
  assign borrow_o = en_i & bw[DATA_W];

endmodule

// File: rtl/div_eight.sv
// Sequential 8-bit unsigned restoring divider: one trial subtraction per
// clock through the ripple subtractor, 8 iterations, registered results.
module div_eight
  import div_eight_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              divByZero
);

  div_state_e        state_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] q_q, rem_q, dvs_q;
  logic [DATA_W-1:0] q_d, rem_d;
  logic              busy_q, done_q, dz_q;
  logic [DATA_W-1:0] quot_q, rmd_q;

  logic [DATA_W-1:0] part_lo;
  logic [DATA_W-1:0] diff;
  logic              borrow;
  logic              accept;

  // Partial value P = {rem, q[7]}; P[8] is rem_q[7], P[7:0] feeds the subtractor.
  assign part_lo = {rem_q[DATA_W-2:0], q_q[DATA_W-1]};

  div_eight_sub u_sub (
    .en_i     (1'b1),
    .a_i      (part_lo),
    .b_i      (dvs_q),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  always_comb begin
    accept = rem_q[DATA_W-1] | ~borrow;
    rem_d  = accept ? diff : part_lo;
    q_d    = {q_q[DATA_W-2:0], accept};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quot_q  <= DIV0_QUOT;
              rmd_q   <= dividend;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DIV_DONE;
            end else begin
              q_q     <= dividend;
              rem_q   <= '0;
              dvs_q   <= divisor;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          q_q   <= q_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            quot_q  <= q_d;
            rmd_q   <= rem_d;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          done_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rmd_q;
  assign divByZero = dz_q;

endmodule

// File: tb/tb_div_eight.sv
// Self-checking bench for div_eight: a cycle-level arithmetic model compared
// against the DUT every cycle, plus directed cases with literal expectations.
module tb_div_eight;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, divByZero;
  logic [7:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  div_eight dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero)
  );

  always #5 clk = ~clk;

  // Reference model: counts remaining busy cycles and computes results with / and %.
  int         m_left;
  logic       m_done;
  logic [7:0] m_q, m_r, p_q, p_r;
  logic       m_dz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dz = 1'b0;
      p_q = '0; p_r = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r; m_dz = 1'b0;
      end
    end else if (start) begin
      if (divisor == 8'd0) begin
        m_done = 1'b1; m_q = 8'hFF; m_r = dividend; m_dz = 1'b1;
      end else begin
        m_left = 8;
        p_q = dividend / divisor;
        p_r = dividend % divisor;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", int'(busy), int'(m_left > 0));
      check("done", int'(done), int'(m_done));
      check("quotient", int'(quotient), int'(m_q));
      check("remainder", int'(remainder), int'(m_r));
      check("divByZero", int'(divByZero), int'(m_dz));
    end
  end

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge after the accepting edge; lat counts that cycle as 1.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 1; busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input int eq, input int er, input int edz, input int elat);
    int lat, bc;
    pulse_start(a, b);
    wait_done(lat, bc);
    check($sformatf("q %0d/%0d", a, b), int'(quotient), eq);
    check($sformatf("r %0d/%0d", a, b), int'(remainder), er);
    check($sformatf("dz %0d/%0d", a, b), int'(divByZero), edz);
    check($sformatf("lat %0d/%0d", a, b), lat, elat);
    check($sformatf("busycyc %0d/%0d", a, b), bc, (elat == 9) ? 8 : 0);
    @(negedge clk);
  endtask

  initial begin
    int lat, bc, ndone;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_dz", int'(divByZero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_div(8'd100, 8'd7, 14, 2, 0, 9);
    run_div(8'd255, 8'd128, 1, 127, 0, 9);
    run_div(8'd255, 8'd1, 255, 0, 0, 9);
    run_div(8'd200, 8'd250, 0, 200, 0, 9);
    run_div(8'd0, 8'd9, 0, 0, 0, 9);
    run_div(8'd5, 8'd0, 255, 5, 1, 1);
    run_div(8'd9, 8'd3, 3, 0, 0, 9);

    // Stray starts during RUN and DONE must be dropped.
    pulse_start(8'd50, 8'd3);
    repeat (3) @(negedge clk);
    check("held_q_run", int'(quotient), 3);
    start = 1'b1; dividend = 8'd9; divisor = 8'd9;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        start = 1'b1; dividend = 8'd9; divisor = 8'd9;
        check("ign_q", int'(quotient), 16);
        check("ign_r", int'(remainder), 2);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ign_done_count", ndone, 1);

    // Asynchronous reset mid-RUN.
    pulse_start(8'd100, 8'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_q", int'(quotient), 0);
    check("arst_r", int'(remainder), 0);
    check("arst_dz", int'(divByZero), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("arst_no_done", ndone, 0);
    run_div(8'd77, 8'd10, 7, 7, 0, 9);

    // Random traffic, including back-to-back and ignored starts.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 2) == 0);
      dividend = 8'($urandom);
      divisor  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
